// File: rtl/cv32e40s_pma_gate.sv
// PMA gate: forwards PMA-legal core transactions to OBI and turns PMA-illegal ones into in-order error responses.
// Optional error log enabled by defining CV32E40S_PMA_GATE_ERR_LOG_EN.
module cv32e40s_pma_gate #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic        clk,
  input  logic        rst,
`ifdef CV32E40S_PMA_GATE_ERR_LOG_EN
  input  logic        err_log_clr_i,
  output logic        err_log_valid_o,
  output logic [31:0] err_log_addr_o,
  output logic        err_log_we_o,
`endif
  input  logic        core_trans_valid_i,
  output logic        core_trans_ready_o,
  input  logic [31:0] core_trans_addr_i,
  input  logic        core_trans_we_i,
  input  logic [31:0] core_trans_wdata_i,
  input  logic        pma_err_i,
  input  logic        pma_bufferable_i,
  input  logic        pma_cacheable_i,
  input  logic        pma_integrity_i,
  output logic        bus_trans_valid_o,
  input  logic        bus_trans_ready_i,
  output logic [31:0] bus_trans_addr_o,
  output logic        bus_trans_we_o,
  output logic [31:0] bus_trans_wdata_o,
  output logic [1:0]  bus_trans_memtype_o,
  output logic        bus_trans_integrity_o,
  input  logic        bus_resp_valid_i,
  input  logic        bus_resp_err_i,
  input  logic [31:0] bus_resp_rdata_i,
  output logic        core_resp_valid_o,
  output logic [1:0]  core_resp_err_o,
  output logic [31:0] core_resp_rdata_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    ERR_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             below_max;
  logic             bus_hs;
  logic             err_accept;

  assign below_max = (cnt_q < CNT_W'(MAX_OUTSTANDING));

  // Request side: only IDLE lets anything through to the bus
  always_comb begin
    bus_trans_valid_o  = 1'b0;
    core_trans_ready_o = 1'b0;
    err_accept         = 1'b0;
    if (state_q == IDLE) begin
      if (core_trans_valid_i && pma_err_i) begin
        core_trans_ready_o = 1'b1;
        err_accept         = 1'b1;
      end else begin
        bus_trans_valid_o  = core_trans_valid_i && below_max;
        core_trans_ready_o = bus_trans_ready_i && below_max;
      end
    end
  end

  assign bus_hs                = bus_trans_valid_o && bus_trans_ready_i;
  assign bus_trans_addr_o      = core_trans_addr_i;
  assign bus_trans_we_o        = core_trans_we_i;
  assign bus_trans_wdata_o     = core_trans_wdata_i;
  assign bus_trans_memtype_o   = {pma_cacheable_i, pma_bufferable_i};
  assign bus_trans_integrity_o = pma_integrity_i;

  // Outstanding counter; a stray response at zero is held at zero
  always_comb begin
    cnt_d = cnt_q;
    if (bus_hs && !bus_resp_valid_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!bus_hs && bus_resp_valid_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (err_accept) begin
          state_d = (cnt_d == '0) ? ERR_RESP : DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_d == '0) begin
          state_d = ERR_RESP;
        end
      end
      ERR_RESP: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Response side: synthesized PMA error replaces the (impossible) bus response
  always_comb begin
    core_resp_valid_o = bus_resp_valid_i;
    core_resp_err_o   = {1'b0, bus_resp_err_i};
    core_resp_rdata_o = bus_resp_rdata_i;
    if (state_q == ERR_RESP) begin
      core_resp_valid_o = 1'b1;
      core_resp_err_o   = 2'b10;
      core_resp_rdata_o = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef CV32E40S_PMA_GATE_ERR_LOG_EN
  logic        log_valid_q, log_valid_d;
  logic [31:0] log_addr_q, log_addr_d;
  logic        log_we_q, log_we_d;

  // First error sticks until cleared; clear wins over a same-cycle capture
  always_comb begin
    log_valid_d = log_valid_q;
    log_addr_d  = log_addr_q;
    log_we_d    = log_we_q;
    if (err_log_clr_i) begin
      log_valid_d = 1'b0;
      log_addr_d  = 32'h0;
      log_we_d    = 1'b0;
    end else if (err_accept && !log_valid_q) begin
      log_valid_d = 1'b1;
      log_addr_d  = core_trans_addr_i;
      log_we_d    = core_trans_we_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      log_valid_q <= 1'b0;
      log_addr_q  <= 32'h0;
      log_we_q    <= 1'b0;
    end else begin
      log_valid_q <= log_valid_d;
      log_addr_q  <= log_addr_d;
      log_we_q    <= log_we_d;
    end
  end

  assign err_log_valid_o = log_valid_q;
  assign err_log_addr_o  = log_addr_q;
  assign err_log_we_o    = log_we_q;
`endif

  a_no_resp_in_err: assert property (@(posedge clk) disable iff (rst)
    !((state_q == ERR_RESP) && bus_resp_valid_i));

  a_no_resp_underflow: assert property (@(posedge clk) disable iff (rst)
    !(bus_resp_valid_i && (cnt_q == '0)));

  a_cnt_bounded: assert property (@(posedge clk) disable iff (rst)
    cnt_q <= CNT_W'(MAX_OUTSTANDING));

  a_pma_stable: assert property (@(posedge clk) disable iff (rst)
    (core_trans_valid_i && !core_trans_ready_o) |=>
      $stable({pma_err_i, pma_bufferable_i, pma_cacheable_i, pma_integrity_i, core_trans_addr_i}));

endmodule

// File: tb/tb_cv32e40s_pma_gate.sv
// Scoreboard bench for cv32e40s_pma_gate: expected bus requests and core responses are queued by the
// directed stimulus and popped by a negedge monitor.
module tb_cv32e40s_pma_gate;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_trans_valid_i, core_trans_ready_o;
  logic [31:0] core_trans_addr_i, core_trans_wdata_i;
  logic        core_trans_we_i;
  logic        pma_err_i, pma_bufferable_i, pma_cacheable_i, pma_integrity_i;
  logic        bus_trans_valid_o, bus_trans_ready_i;
  logic [31:0] bus_trans_addr_o, bus_trans_wdata_o;
  logic        bus_trans_we_o, bus_trans_integrity_o;
  logic [1:0]  bus_trans_memtype_o;
  logic        bus_resp_valid_i, bus_resp_err_i;
  logic [31:0] bus_resp_rdata_i;
  logic        core_resp_valid_o;
  logic [1:0]  core_resp_err_o;
  logic [31:0] core_resp_rdata_o;
`ifdef CV32E40S_PMA_GATE_ERR_LOG_EN
  logic        err_log_clr_i, err_log_valid_o, err_log_we_o;
  logic [31:0] err_log_addr_o;
`endif

  cv32e40s_pma_gate #(.MAX_OUTSTANDING(2)) dut (
    .clk                   (clk),
    .rst                   (rst),
`ifdef CV32E40S_PMA_GATE_ERR_LOG_EN
    .err_log_clr_i         (err_log_clr_i),
    .err_log_valid_o       (err_log_valid_o),
    .err_log_addr_o        (err_log_addr_o),
    .err_log_we_o          (err_log_we_o),
`endif
    .core_trans_valid_i    (core_trans_valid_i),
    .core_trans_ready_o    (core_trans_ready_o),
    .core_trans_addr_i     (core_trans_addr_i),
    .core_trans_we_i       (core_trans_we_i),
    .core_trans_wdata_i    (core_trans_wdata_i),
    .pma_err_i             (pma_err_i),
    .pma_bufferable_i      (pma_bufferable_i),
    .pma_cacheable_i       (pma_cacheable_i),
    .pma_integrity_i       (pma_integrity_i),
    .bus_trans_valid_o     (bus_trans_valid_o),
    .bus_trans_ready_i     (bus_trans_ready_i),
    .bus_trans_addr_o      (bus_trans_addr_o),
    .bus_trans_we_o        (bus_trans_we_o),
    .bus_trans_wdata_o     (bus_trans_wdata_o),
    .bus_trans_memtype_o   (bus_trans_memtype_o),
    .bus_trans_integrity_o (bus_trans_integrity_o),
    .bus_resp_valid_i      (bus_resp_valid_i),
    .bus_resp_err_i        (bus_resp_err_i),
    .bus_resp_rdata_i      (bus_resp_rdata_i),
    .core_resp_valid_o     (core_resp_valid_o),
    .core_resp_err_o       (core_resp_err_o),
    .core_resp_rdata_o     (core_resp_rdata_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [1:0]  mt;
    logic        integ;
  } bus_t;

  typedef struct packed {
    logic [1:0]  err;
    logic [31:0] rdata;
  } rsp_t;

  bus_t bus_q[$];
  rsp_t rsp_q[$];
  bus_t bus_exp, bus_act;
  rsp_t rsp_exp, rsp_act;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a bus handshake or core response
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_trans_valid_o && bus_trans_ready_i) begin
        bus_act = '{bus_trans_addr_o, bus_trans_we_o, bus_trans_wdata_o,
                    bus_trans_memtype_o, bus_trans_integrity_o};
        if (bus_q.size() == 0) begin
          chk("bus_unexpected", {64'h0, bus_trans_addr_o}, 96'hFFFF_FFFF);
        end else begin
          bus_exp = bus_q.pop_front();
          chk("bus_req", 96'(bus_act), 96'(bus_exp));
        end
      end
      if (core_resp_valid_o) begin
        rsp_act = '{core_resp_err_o, core_resp_rdata_o};
        if (rsp_q.size() == 0) begin
          chk("resp_unexpected", 96'(rsp_act), 96'h1_FFFF_FFFF_F);
        end else begin
          rsp_exp = rsp_q.pop_front();
          chk("core_resp", 96'(rsp_act), 96'(rsp_exp));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    core_trans_valid_i = 1'b0;
    core_trans_addr_i  = 32'h0;
    core_trans_we_i    = 1'b0;
    core_trans_wdata_i = 32'h0;
    pma_err_i          = 1'b0;
    pma_bufferable_i   = 1'b0;
    pma_cacheable_i    = 1'b0;
    pma_integrity_i    = 1'b0;
    bus_trans_ready_i  = 1'b0;
    bus_resp_valid_i   = 1'b0;
    bus_resp_err_i     = 1'b0;
    bus_resp_rdata_i   = 32'h0;
`ifdef CV32E40S_PMA_GATE_ERR_LOG_EN
    err_log_clr_i      = 1'b0;
`endif
  endtask

  task automatic req(input logic [31:0] a, input logic we, input logic [31:0] wd,
                     input logic err, input logic c, input logic b, input logic i);
    core_trans_valid_i = 1'b1;
    core_trans_addr_i  = a;
    core_trans_we_i    = we;
    core_trans_wdata_i = wd;
    pma_err_i          = err;
    pma_cacheable_i    = c;
    pma_bufferable_i   = b;
    pma_integrity_i    = i;
  endtask

  task automatic resp(input logic e, input logic [31:0] d);
    bus_resp_valid_i = 1'b1;
    bus_resp_err_i   = e;
    bus_resp_rdata_i = d;
  endtask

  task automatic no_req();
    core_trans_valid_i = 1'b0;
    pma_err_i          = 1'b0;
  endtask

  task automatic no_resp();
    bus_resp_valid_i = 1'b0;
    bus_resp_err_i   = 1'b0;
    bus_resp_rdata_i = 32'h0;
  endtask

  task automatic push_bus(input logic [31:0] a, input logic we, input logic [31:0] wd,
                          input logic [1:0] mt, input logic i);
    bus_q.push_back('{a, we, wd, mt, i});
  endtask

  task automatic push_rsp(input logic [1:0] e, input logic [31:0] d);
    rsp_q.push_back('{e, d});
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("reset_bus_valid",   {95'h0, bus_trans_valid_o}, 96'h0);
    chk("reset_core_ready",  {95'h0, core_trans_ready_o}, 96'h0);
    chk("reset_resp",        {61'h0, core_resp_valid_o, core_resp_err_o, core_resp_rdata_o}, 96'h0);
    chk("reset_bus_fields",  {28'h0, bus_trans_addr_o, bus_trans_we_o, bus_trans_memtype_o,
                              bus_trans_integrity_o}, 96'h0);

    // Legal read, granted same cycle, then read data passes through
    tick();
    req(32'h0000_1000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    bus_trans_ready_i = 1'b1;
    #1;
    chk("legal_bus_valid", {95'h0, bus_trans_valid_o}, 96'h1);
    chk("legal_ready",     {95'h0, core_trans_ready_o}, 96'h1);
    chk("legal_memtype",   {94'h0, bus_trans_memtype_o}, 96'h2);
    push_bus(32'h0000_1000, 1'b0, 32'h0, 2'b10, 1'b0);
    tick();
    idle_in();
    resp(1'b0, 32'hDEAD_BEEF);
    push_rsp(2'b00, 32'hDEAD_BEEF);
    tick();
    idle_in();

    // Saturation at two outstanding
    bus_trans_ready_i = 1'b1;
    req(32'h0000_2000, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b1, 1'b1);
    push_bus(32'h0000_2000, 1'b1, 32'h1111_1111, 2'b01, 1'b1);
    tick();
    req(32'h0000_2004, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    push_bus(32'h0000_2004, 1'b0, 32'h0, 2'b11, 1'b0);
    tick();
    req(32'h0000_2008, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("sat_bus_valid", {95'h0, bus_trans_valid_o}, 96'h0);
    chk("sat_ready",     {95'h0, core_trans_ready_o}, 96'h0);
    tick();
    chk("sat_hold_valid", {95'h0, bus_trans_valid_o}, 96'h0);
    resp(1'b0, 32'hAAAA_0001);
    push_rsp(2'b00, 32'hAAAA_0001);
    #1;
    chk("sat_resp_cycle_valid", {95'h0, bus_trans_valid_o}, 96'h0);
    tick();
    no_resp();
    #1;
    chk("sat_release_valid", {95'h0, bus_trans_valid_o}, 96'h1);
    push_bus(32'h0000_2008, 1'b0, 32'h0, 2'b00, 1'b0);
    tick();
    no_req();
    bus_trans_ready_i = 1'b0;
    resp(1'b0, 32'hAAAA_0002);
    push_rsp(2'b00, 32'hAAAA_0002);
    tick();
    resp(1'b0, 32'hAAAA_0003);
    push_rsp(2'b00, 32'hAAAA_0003);
    tick();
    idle_in();

    // Illegal access with nothing outstanding
    req(32'h0000_3000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    bus_trans_ready_i = 1'b1;
    #1;
    chk("err0_bus_valid", {95'h0, bus_trans_valid_o}, 96'h0);
    chk("err0_ready",     {95'h0, core_trans_ready_o}, 96'h1);
    push_rsp(2'b10, 32'h0);
    tick();
    req(32'h0000_3100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("errresp_bus_valid", {95'h0, bus_trans_valid_o}, 96'h0);
    chk("errresp_ready",     {95'h0, core_trans_ready_o}, 96'h0);
    chk("errresp_valid",     {95'h0, core_resp_valid_o}, 96'h1);
    tick();
    chk("after_err_bus_valid", {95'h0, bus_trans_valid_o}, 96'h1);
    push_bus(32'h0000_3100, 1'b0, 32'h0, 2'b00, 1'b0);
    tick();
    idle_in();
    resp(1'b0, 32'h1234_5678);
    push_rsp(2'b00, 32'h1234_5678);
    tick();
    idle_in();

    // Illegal access behind two outstanding: drain first
    bus_trans_ready_i = 1'b1;
    req(32'h0000_4000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    push_bus(32'h0000_4000, 1'b0, 32'h0, 2'b00, 1'b1);
    tick();
    req(32'h0000_4004, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    push_bus(32'h0000_4004, 1'b0, 32'h0, 2'b00, 1'b1);
    tick();
    req(32'h0000_4100, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("err2_ready",     {95'h0, core_trans_ready_o}, 96'h1);
    chk("err2_bus_valid", {95'h0, bus_trans_valid_o}, 96'h0);
    push_rsp(2'b00, 32'hB000_0001);
    push_rsp(2'b01, 32'hB000_0002);
    push_rsp(2'b10, 32'h0);
    tick();
    req(32'h0000_4200, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("drain_ready",     {95'h0, core_trans_ready_o}, 96'h0);
    chk("drain_bus_valid", {95'h0, bus_trans_valid_o}, 96'h0);
    tick();
    resp(1'b0, 32'hB000_0001);
    #1;
    chk("drain_r1_ready", {95'h0, core_trans_ready_o}, 96'h0);
    tick();
    resp(1'b1, 32'hB000_0002);
    #1;
    chk("drain_r2_bus_valid", {95'h0, bus_trans_valid_o}, 96'h0);
    tick();
    no_resp();
    #1;
    chk("drain_err_valid", {95'h0, core_resp_valid_o}, 96'h1);
    chk("drain_err_code",  {94'h0, core_resp_err_o}, 96'h2);
    chk("drain_err_ready", {95'h0, core_trans_ready_o}, 96'h0);
    tick();
    chk("drain_done_bus_valid", {95'h0, bus_trans_valid_o}, 96'h1);
    push_bus(32'h0000_4200, 1'b0, 32'h0, 2'b00, 1'b0);
    tick();
    idle_in();
    resp(1'b0, 32'hB000_0003);
    push_rsp(2'b00, 32'hB000_0003);
    tick();
    idle_in();

    // Reset in DRAIN discards the pending error and clears the counter
    bus_trans_ready_i = 1'b1;
    req(32'h0000_5000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_bus(32'h0000_5000, 1'b0, 32'h0, 2'b00, 1'b0);
    tick();
    req(32'h0000_5100, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_err_ready", {95'h0, core_trans_ready_o}, 96'h1);
    tick();
    idle_in();
    rst = 1'b1;
    #1;
    chk("drain_no_resp", {95'h0, core_resp_valid_o}, 96'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_no_resp", {95'h0, core_resp_valid_o}, 96'h0);
    bus_trans_ready_i = 1'b1;
    req(32'h0000_5200, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_bus(32'h0000_5200, 1'b0, 32'h0, 2'b00, 1'b0);
    tick();
    req(32'h0000_5204, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    chk("post_rst_second_valid", {95'h0, bus_trans_valid_o}, 96'h1);
    push_bus(32'h0000_5204, 1'b1, 32'hCAFE_F00D, 2'b11, 1'b1);
    tick();
    idle_in();
    resp(1'b0, 32'hC000_0001);
    push_rsp(2'b00, 32'hC000_0001);
    tick();
    resp(1'b0, 32'hC000_0002);
    push_rsp(2'b00, 32'hC000_0002);
    tick();
    idle_in();

`ifdef CV32E40S_PMA_GATE_ERR_LOG_EN
    req(32'h4000_0000, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    push_rsp(2'b10, 32'h0);
    tick();
    idle_in();
    tick();
    req(32'h5000_0000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    push_rsp(2'b10, 32'h0);
    tick();
    idle_in();
    #1;
    chk("log_first", {63'h0, err_log_valid_o, err_log_addr_o}, {63'h0, 1'b1, 32'h4000_0000});
    chk("log_we",    {95'h0, err_log_we_o}, 96'h1);
    tick();
    err_log_clr_i = 1'b1;
    tick();
    err_log_clr_i = 1'b0;
    #1;
    chk("log_cleared", {95'h0, err_log_valid_o}, 96'h0);
    req(32'h6000_0000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    push_rsp(2'b10, 32'h0);
    tick();
    idle_in();
    #1;
    chk("log_second", {62'h0, err_log_valid_o, err_log_we_o, err_log_addr_o},
                      {62'h0, 1'b1, 1'b0, 32'h6000_0000});
    tick();
`endif

    repeat (3) tick();
    chk("bus_queue_empty",  96'(bus_q.size()), 96'h0);
    chk("resp_queue_empty", 96'(rsp_q.size()), 96'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cv32e40s_pma_gate.md
Name: cv32e40s_pma_gate

Overview:
Sits directly downstream of the PMA checker, between the core-side LSU/IF transaction interface and the OBI bus interface. It consumes the PMA verdict and attributes for the current transaction. A legal transaction is forwarded to the bus with memtype/integrity attached. An illegal one is suppressed, outstanding bus traffic is drained, and the block synthesizes an in-order error response back to the core.

Parameters:
MAX_OUTSTANDING, 2, max bus transactions accepted but not yet responded (1..7)
CNT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter (derived; do not override)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
core_trans_valid_i  in  1  core transaction request
core_trans_ready_o  out  1  transaction accepted by gate
core_trans_addr_i  in  32  transaction byte address
core_trans_we_i  in  1  write enable
core_trans_wdata_i  in  32  write data
pma_err_i  in  1  PMA verdict for current core_trans_addr_i (combinational from PMA)
pma_bufferable_i  in  1  PMA bufferable attribute
pma_cacheable_i  in  1  PMA cacheable attribute
pma_integrity_i  in  1  PMA integrity attribute
bus_trans_valid_o  out  1  OBI request
bus_trans_ready_i  in  1  OBI grant
bus_trans_addr_o  out  32  forwarded address
bus_trans_we_o  out  1  forwarded write enable
bus_trans_wdata_o  out  32  forwarded write data
bus_trans_memtype_o  out  2  {cacheable, bufferable}
bus_trans_integrity_o  out  1  forwarded integrity attribute
bus_resp_valid_i  in  1  OBI response valid
bus_resp_err_i  in  1  OBI bus error
bus_resp_rdata_i  in  32  OBI read data
core_resp_valid_o  out  1  response to core
core_resp_err_o  out  2  [0] bus error, [1] PMA error
core_resp_rdata_o  out  32  read data (0 on PMA error)

Behaviour:
- Registered state: fsm (IDLE, DRAIN, ERR_RESP) and outstanding counter cnt. On rst: fsm=IDLE, cnt=0. All outputs are combinational from state and inputs. With inputs idle after reset, every output is 0.
- IDLE, pma_err_i=0:
  - bus_trans_valid_o = core_trans_valid_i && (cnt < MAX_OUTSTANDING).
  - core_trans_ready_o = bus_trans_ready_i && (cnt < MAX_OUTSTANDING).
  - addr/we/wdata pass through. memtype and integrity are taken from the pma_* inputs.
  - Zero-cycle latency.
- IDLE, core_trans_valid_i=1, pma_err_i=1:
  - bus_trans_valid_o=0 and core_trans_ready_o=1, so the transaction is consumed.
  - Next state: if cnt_next==0 then ERR_RESP, else DRAIN.
- cnt_next = cnt + bus handshake − bus_resp_valid_i. A simultaneous handshake and response leaves cnt unchanged.
- Error responses remain in order behind all earlier bus transactions.
- DRAIN: core_trans_ready_o=0 and bus_trans_valid_o=0. Bus responses pass through. Go to ERR_RESP when cnt_next==0.
- ERR_RESP, held for exactly 1 cycle:
  - core_resp_valid_o=1, core_resp_err_o=2'b10, core_resp_rdata_o=0.
  - core_trans_ready_o=0 and bus_trans_valid_o=0.
  - Next state is IDLE.
- Bus responses are passed through combinationally: core_resp_valid_o=bus_resp_valid_i, core_resp_err_o={1'b0,bus_resp_err_i}, core_resp_rdata_o=bus_resp_rdata_i. A bus response in ERR_RESP cannot occur because cnt==0; an assertion covers this.
- Saturation:
  - cnt never exceeds MAX_OUTSTANDING; at the limit, requests stall in IDLE.
  - A bus response with cnt==0 does not underflow (cnt holds 0) and is flagged by an assertion.
- Once bus_trans_valid_o rises, it stays high with stable address/attributes until the grant. The PMA inputs are required stable while core_trans_valid_i is high.
- rst mid-DRAIN or mid-ERR_RESP: return to IDLE with cnt=0. The pending error response is discarded.

Optional Feature:
Macro CV32E40S_PMA_GATE_ERR_LOG_EN.
- When defined, adds ports err_log_valid_o (1), err_log_addr_o (32), err_log_we_o (1) and err_log_clr_i (1).
- On the first PMA-error acceptance while err_log_valid_o=0:
  - Capture core_trans_addr_i and core_trans_we_i.
  - Set err_log_valid_o on the next cycle.
- Later errors do not overwrite the log until err_log_clr_i=1. Clear has priority over a same-cycle capture.
- On rst: valid=0, addr=0, we=0.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Legal read to 0x0000_1000, pma_err=0, cacheable=1, bufferable=0, gnt same cycle -> bus valid same cycle, memtype=2'b10, cnt 0->1, response rdata 0xDEADBEEF passed through with err=2'b00.
- Two legal requests granted, no responses, third request with MAX_OUTSTANDING=2 -> bus_trans_valid_o=0 and core_trans_ready_o=0 until one response arrives, then the third issues.
- Illegal fetch with cnt=0 -> ready=1, no bus request, next cycle core_resp_valid_o=1, err=2'b10, rdata=0, then IDLE.
- Illegal access with cnt=2 -> DRAIN. Two bus responses are forwarded first, then ERR_RESP in the cycle after cnt reaches 0. No new request is accepted in DRAIN.
- rst asserted in DRAIN with cnt=1 -> next cycle fsm=IDLE, cnt=0, no error response emitted.
- With CV32E40S_PMA_GATE_ERR_LOG_EN: errors at 0x4000_0000 (write) then 0x5000_0000 -> log holds 0x4000_0000, we=1. After err_log_clr_i, the next error at 0x6000_0000 is captured.
